x_uart_tx_arb: RTL and testbench

Round-robin arbiter that shares one `x_uart_tx` serialiser between `p_num` byte-stream requesters. It sits between several internal producers (FIFO drains, status reporters) and the single UART TX pin. It grants one requester at a time for a burst of up to `p_max_burst` bytes, then rotates fairly.

---
 rtl/x_uart_pkg.sv | 5 +
 rtl/x_rr_pick.sv | 22 ++
 rtl/x_uart_tx.sv | 44 ++++
 rtl/x_uart_tx_arb.sv | 92 +++++++++
 tb/tb_x_uart_tx_arb.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/x_uart_pkg.sv
// x_uart_pkg: shared types and constants for the UART transmit arbiter.
package x_uart_pkg;
    typedef enum logic [1:0] {IDLE, TAG, DATA} arb_state_e;
    localparam logic [7:0] TAG_BASE = 8'h80;
endpackage

// File: rtl/x_rr_pick.sv
// x_rr_pick: combinational round-robin winner search starting just after i_last.
module x_rr_pick #(
    parameter int p_num = 4
) (
    input  logic [p_num-1:0]         i_req,
    input  logic [$clog2(p_num)-1:0] i_last,
    output logic [p_num-1:0]         o_win,
    output logic [$clog2(p_num)-1:0] o_idx
);
    localparam int W = $clog2(p_num);
    logic [W-1:0] w_j;
    // Walk farthest-to-nearest so the closest requester after i_last overwrites last.
    always_comb begin
        o_idx = '0;
        w_j = '0;
        for (int k = p_num; k >= 1; k--) begin
            w_j = W'((int'(i_last) + k) % p_num);
            if (i_req[w_j]) o_idx = w_j;
        end
    end
    assign o_win = |i_req ? p_num'(1) << o_idx : '0;
endmodule

// File: rtl/x_uart_tx.sv
// x_uart_tx: 8N1 serialiser; takes a byte when idle, one bit per p_clk_hz/p_baud cycles.
module x_uart_tx #(
    parameter int p_clk_hz = 12000000,
    parameter int p_baud   = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);
    localparam int DIV = p_clk_hz / p_baud;
    localparam int DW = $clog2(DIV + 1);
    logic          r_act;
    logic [9:0]    r_sh;
    logic [3:0]    r_bit;
    logic [DW-1:0] r_div;
    assign o_ready = !r_act;
    // Idle level derives straight from r_act so an async reset forces the line high at once.
    assign o_tx = !r_act || r_sh[0];
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_act <= 1'b0;
            r_sh <= '1;
            r_bit <= '0;
            r_div <= '0;
        end else if (!r_act) begin
            if (i_valid) begin
                r_act <= 1'b1;
                r_sh <= {1'b1, i_data, 1'b0};
                r_bit <= '0;
                r_div <= '0;
            end
        end else if (r_div == DW'(DIV - 1)) begin
            r_div <= '0;
            r_sh <= {1'b1, r_sh[9:1]};
            r_bit <= r_bit + 1'b1;
            if (r_bit == 4'd9) r_act <= 1'b0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end
endmodule

// File: rtl/x_uart_tx_arb.sv
// x_uart_tx_arb: round-robin sharing of one x_uart_tx among p_num byte streams, bursts of up to p_max_burst.
// Define X_UART_TX_ARB_TAG_EN to prefix every burst with header byte 8'h80 | index.
module x_uart_tx_arb
    import x_uart_pkg::*;
#(
    parameter int p_clk_hz    = 12000000,
    parameter int p_baud      = 115200,
    parameter int p_num       = 4,
    parameter int p_max_burst = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [p_num-1:0]      i_valid,
    input  logic [p_num-1:0][7:0] i_data,
    output logic [p_num-1:0]      o_accept,
    output logic [p_num-1:0]      o_grant,
    output logic                  o_busy,
    output logic                  o_tx
);
    localparam int W = $clog2(p_num);
    localparam int CW = $clog2(p_max_burst + 1);
    arb_state_e       r_state;
    logic [W-1:0]     r_last, r_gidx, w_win_idx;
    logic [p_num-1:0] r_grant, w_win;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             w_tx_valid, w_tx_ready, w_tx_acc;
    logic [7:0]       w_tx_data;
    x_rr_pick #(.p_num(p_num)) u_pick (
        .i_req (i_valid),
        .i_last(r_last),
        .o_win (w_win),
        .o_idx (w_win_idx)
    );
`ifdef X_UART_TX_ARB_TAG_EN
    assign w_tx_valid = (r_state == TAG) || (r_state == DATA && i_valid[r_gidx]);
    assign w_tx_data = (r_state == TAG) ? (TAG_BASE | 8'(r_gidx)) : i_data[r_gidx];
`else
    assign w_tx_valid = r_state == DATA && i_valid[r_gidx];
    assign w_tx_data = i_data[r_gidx];
`endif
    assign w_tx_acc = w_tx_valid && w_tx_ready;
    assign o_accept = (r_state == DATA && w_tx_acc) ? r_grant : '0;
    assign o_grant = r_grant;
    assign o_busy = r_busy;
    x_uart_tx #(.p_clk_hz(p_clk_hz), .p_baud(p_baud)) u_tx (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(w_tx_valid),
        .i_data (w_tx_data),
        .o_ready(w_tx_ready),
        .o_tx   (o_tx)
    );
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_last <= W'(p_num - 1);
            r_gidx <= '0;
            r_grant <= '0;
            r_cnt <= '0;
            r_busy <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (|i_valid) begin
                    r_gidx <= w_win_idx;
                    r_last <= w_win_idx;
                    r_grant <= w_win;
                    r_cnt <= '0;
                    r_busy <= 1'b1;
`ifdef X_UART_TX_ARB_TAG_EN
                    r_state <= TAG;
`else
                    r_state <= DATA;
`endif
                end
`ifdef X_UART_TX_ARB_TAG_EN
                TAG: if (w_tx_acc) r_state <= DATA;
`endif
                DATA: begin
                    if (w_tx_acc) r_cnt <= r_cnt + 1'b1;
                    // A dropped valid only ends the burst once the serialiser is free again.
                    if ((w_tx_acc && r_cnt + 1'b1 == CW'(p_max_burst)) || (!i_valid[r_gidx] && w_tx_ready)) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_busy <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_x_uart_tx_arb.sv
// tb_x_uart_tx_arb: directed scenarios for x_uart_tx_arb with a bench-side serial line decoder.
module tb_x_uart_tx_arb;
    localparam int DIV = 12000000 / 115200;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      valid = '0;
    logic [3:0][7:0] data = '0;
    logic [3:0]      acc, grant;
    logic            busy, tx;
    logic [7:0]      tq[4][$];
    int              gq[$], eg[$], aq[$], ea[$], gapq[$];
    logic [7:0]      rxq[$], er[$];
    int              n_chk = 0;
    int              n_fail = 0;
    int              rst_gen = 0;
    int              lowrun = 0;
    int              rx_g;
    logic [3:0]      g_prev = '0;
    logic [3:0]      acc_s;
    logic [7:0]      rx_b;

    x_uart_tx_arb #(.p_clk_hz(12000000), .p_baud(115200), .p_num(4), .p_max_burst(8)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_data  (data),
        .o_accept(acc),
        .o_grant (grant),
        .o_busy  (busy),
        .o_tx    (tx)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge rst);
        rst_gen++;
    end

    // Requester models and log monitor: sample at negedge, advance queues just after posedge.
    initial forever begin
        @(negedge clk);
        acc_s = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) aq.push_back(i);
            if (grant[i] && g_prev == 4'b0000) gq.push_back(i);
        end
        g_prev = grant;
        if (!busy) lowrun++;
        else begin
            if (lowrun > 0) gapq.push_back(lowrun);
            lowrun = 0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc_s[i]) void'(tq[i].pop_front());
            valid[i] = tq[i].size() > 0;
            data[i] = valid[i] ? tq[i][0] : 8'h00;
        end
    end

    // Line decoder: samples each data bit mid-period, drops any frame cut by reset.
    initial forever begin
        @(negedge clk);
        if (!rst && tx === 1'b0) begin
            rx_g = rst_gen;
            rx_b = '0;
            for (int c = 1; c <= 9 * DIV + DIV / 2 && rx_g == rst_gen; c++) begin
                @(negedge clk);
                if (c >= DIV + DIV / 2 && c <= 8 * DIV + DIV / 2 && (c - DIV / 2) % DIV == 0)
                    rx_b[(c - DIV / 2) / DIV - 1] = tx;
            end
            if (rx_g == rst_gen) rxq.push_back(rx_b);
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(int r, int n, logic [7:0] b, logic [7:0] s);
        for (int k = 0; k < n; k++) tq[r].push_back(b + 8'(k) * s);
    endtask

    task automatic exp_grant(int r);
        eg.push_back(r);
`ifdef X_UART_TX_ARB_TAG_EN
        er.push_back(8'h80 | 8'(r));
`endif
    endtask

    task automatic exp_bytes(int r, int n, logic [7:0] b, logic [7:0] s);
        for (int k = 0; k < n; k++) begin
            ea.push_back(r);
            er.push_back(b + 8'(k) * s);
        end
    endtask

    task automatic clear_logs();
        gq.delete();
        aq.delete();
        rxq.delete();
        gapq.delete();
        eg.delete();
        ea.delete();
        er.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(string tag);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while ((busy || tq[0].size() + tq[1].size() + tq[2].size() + tq[3].size() > 0) && c < 40000);
        check({tag, "_done"}, 32'(c < 40000), 1);
        repeat (11 * DIV) @(negedge clk);
    endtask

    task automatic chk_logs(string tag);
        check({tag, "_ngrant"}, gq.size(), eg.size());
        for (int k = 0; k < eg.size() && k < gq.size(); k++) check($sformatf("%s_grant%0d", tag, k), gq[k], eg[k]);
        check({tag, "_naccept"}, aq.size(), ea.size());
        for (int k = 0; k < ea.size() && k < aq.size(); k++) check($sformatf("%s_accept%0d", tag, k), aq[k], ea[k]);
        check({tag, "_nrx"}, rxq.size(), er.size());
        for (int k = 0; k < er.size() && k < rxq.size(); k++) check($sformatf("%s_rx%0d", tag, k), rxq[k], er[k]);
    endtask

    initial begin
        int cyc;
        #2;
        check("rst_tx", tx, 1);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_accept", acc, 0);
        do_reset();
        // Single requester, grant latency of one cycle.
        clear_logs();
        load(2, 3, 8'h11, 8'h11);
        @(negedge clk);
        check("s1_grant_n", grant, 4'b0000);
        @(negedge clk);
        check("s1_grant_n1", grant, 4'b0100);
        check("s1_busy_n1", busy, 1);
        exp_grant(2);
        exp_bytes(2, 3, 8'h11, 8'h11);
        wait_done("s1");
        chk_logs("s1");
        // All four from reset, two bytes each.
        do_reset();
        clear_logs();
        for (int r = 0; r < 4; r++) begin
            load(r, 2, 8'hA0 + 8'(r * 16), 8'h01);
            exp_grant(r);
            exp_bytes(r, 2, 8'hA0 + 8'(r * 16), 8'h01);
        end
        wait_done("s2");
        chk_logs("s2");
        check("s2_ngap", gapq.size(), 4);
        for (int k = 1; k < 4 && k < gapq.size(); k++) check($sformatf("s2_gap%0d", k), gapq[k], 1);
        // Burst limit with a competing single-byte requester.
        clear_logs();
        load(1, 20, 8'h40, 8'h01);
        load(3, 1, 8'h5A, 8'h00);
        exp_grant(1);
        exp_bytes(1, 8, 8'h40, 8'h01);
        exp_grant(3);
        exp_bytes(3, 1, 8'h5A, 8'h00);
        exp_grant(1);
        exp_bytes(1, 8, 8'h48, 8'h01);
        exp_grant(1);
        exp_bytes(1, 4, 8'h50, 8'h01);
        wait_done("s3");
        chk_logs("s3");
        // Fairness wrap from last index 3.
        do_reset();
        clear_logs();
        load(3, 1, 8'hC3, 8'h00);
        load(0, 1, 8'hC0, 8'h00);
        exp_grant(0);
        exp_bytes(0, 1, 8'hC0, 8'h00);
        exp_grant(3);
        exp_bytes(3, 1, 8'hC3, 8'h00);
        wait_done("s4");
        chk_logs("s4");
        // Reset in the middle of data bit 4.
        do_reset();
        clear_logs();
        load(0, 2, 8'h00, 8'h55);
        load(1, 1, 8'h66, 8'h00);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!acc[0] && cyc < 5000);
        check("s5_acc_seen", acc[0], 1);
        repeat (5 * DIV + DIV / 2) @(negedge clk);
        check("s5_bit4_low", tx, 0);
        #1 rst = 1'b1;
        #1;
        check("s5_rst_tx", tx, 1);
        check("s5_rst_grant", grant, 0);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_accept", acc, 0);
        clear_logs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_grant(0);
        exp_bytes(0, 1, 8'h55, 8'h00);
        exp_grant(1);
        exp_bytes(1, 1, 8'h66, 8'h00);
        wait_done("s5");
        chk_logs("s5");
        // Early release after one byte.
        clear_logs();
        load(0, 1, 8'h7E, 8'h00);
        exp_grant(0);
        exp_bytes(0, 1, 8'h7E, 8'h00);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!busy && cyc < 100);
        check("s6_busy", busy, 1);
        do begin
            @(negedge clk);
            cyc++;
        end while (busy && cyc < 5000);
        check("s6_busy_low", busy, 0);
        check("s6_idle_grant", grant, 0);
        check("s6_idle_accept", acc, 0);
        check("s6_cnt", dut.r_cnt, 1);
        wait_done("s6");
        chk_logs("s6");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
